smp_timer_bank: RTL and testbench
=================================

// Module: smp_timer_bank
// PURPOSE
//  Parametrised SMP timer bank: NUM_TIMERS independent 2-stage timers (shared prescaler ->
//  per-timer DIV_W divider -> OUT_W wrap-around output counter), generalising the fixed
//  3-timer $FA-$FF logic. Sits beside the SMP I/O decode; decode drives per-timer strobes.
// PARAMETERS
//  NUM_TIMERS   3       number of timers
//  DIV_W        8       divisor/stage-2 counter width; divisor 0 == 2^DIV_W
//  OUT_W        4       output counter width (wraps)
//  PRE_SLOW     128     slow prescale period in CE cycles (power of 2)
//  PRE_FAST     16      fast prescale period in CE cycles (power of 2, <= PRE_SLOW)
//  FAST_MASK    3'b100  bit i=1: timer i uses fast tick, else slow tick
// PORTS
//  CLK       in   1                     clock
//  RST_N     in   1                     synchronous reset, active-low
//  CE        in   1                     SMP clock enable; all state updates qualified by CE
//  EN_WR     in   1                     write enables (control reg write)
//  EN_DATA   in   NUM_TIMERS            new enable vector
//  DIV_WR    in   NUM_TIMERS            per-timer divisor write strobe
//  DIV_DATA  in   DIV_W                 divisor value
//  OUT_RD    in   NUM_TIMERS            per-timer output read strobe (read-to-clear)
//  OUT       out  NUM_TIMERS*OUT_W      packed output counters, timer i at [i*OUT_W +: OUT_W]
//  DIV_Q     out  NUM_TIMERS*DIV_W      packed current divisors (debug readback)
//  TICK      out  NUM_TIMERS            1-cycle pulse when timer i output increments
//  IRQ       out  NUM_TIMERS            only with SMP_TIMER_IRQ_EN, see CONFIGURATION
// BEHAVIOUR
//  Reset: prescaler 0, EN 0, CNT 0, OUT 0, DIV all-ones, TICK 0, IRQ 0.
//  Prescaler: log2(PRE_SLOW)-bit free-running, +1 per CE. slow_tick = pre==PRE_SLOW-1;
//   fast_tick = pre[log2(PRE_FAST)-1:0] all ones. Both combinational from pre, used same cycle.
//  Per timer i on CE, if EN[i] and its tick: CNT+1 (DIV_W bits) == DIV -> CNT<=0, OUT<=OUT+1
//   (wraps 2^OUT_W-1 -> 0), TICK[i]<=1 next cycle; else CNT<=CNT+1.
//  Divisor 0: CNT+1 wraps to 0 at 2^DIV_W-1 -> period 2^DIV_W ticks.
//  EN_WR: EN<=EN_DATA. Bit 0->1 transition: CNT<=0, OUT<=0 same cycle, tick ignored that cycle.
//   1->0: CNT/OUT hold. 1->1: no clear.
//  DIV_WR[i]: DIV<=DIV_DATA immediately; CNT not reset. If CNT>=new DIV, CNT runs to wrap.
//   DIV_WR coincident with a tick: compare uses the old DIV.
//  OUT_RD[i] (CE): OUT<=0, unless increment same cycle -> OUT<=1 (increment never lost).
//   OUT port shows pre-clear value in the read cycle (reader samples combinationally).
//  Strobes with CE=0 are ignored; held state otherwise unchanged. Reset mid-count: all to reset.
//  Latency: OUT/TICK update 1 CLK after qualifying CE edge; no stall/backpressure.
// CONFIGURATION
//  SMP_TIMER_IRQ_EN defined: IRQ[i] level, set on OUT increment of timer i, cleared by OUT_RD[i]
//   or EN 0->1; set wins over clear in same cycle. Adds IRQ port.
//  Not defined: IRQ port absent, no IRQ logic; all other behaviour identical.
// TESTING
//  Reset, EN=3'b001, DIV0=2, run 4*128 CE -> OUT0=2, TICK0 pulses at CE 255 and 511, OUT1/2=0.
//  Timer2 EN, DIV2=0 -> first increment after 256*16=4096 CE; 16 increments -> OUT2 wraps to 0.
//  OUT_RD0 on same CE as OUT0 increment 5->6 -> OUT0=1; OUT_RD0 alone -> OUT0=0.
//  EN0 1->0 at OUT0=3, wait 1000 CE -> OUT0=3; 0->1 -> OUT0=0, CNT0=0.
//  CNT0=10, DIV_WR0 with 5 -> CNT0 runs to 255, wraps, next increments every 5 ticks.
//  SMP_TIMER_IRQ_EN: increment sets IRQ0=1; OUT_RD0 clears; coincident inc+read -> IRQ0=1.

Source files
------------

// File: rtl/smp_timer_bank.sv
// smp_timer_bank
//   Bank of NUM_TIMERS independent SMP timers. A shared free-running prescaler
//   supplies a slow and a fast tick; each timer picks one (FAST_MASK), divides
//   it by its own DIV_W-bit divisor and counts the result in an OUT_W-bit
//   wrap-around output counter that the CPU reads (read-to-clear).
//   All state changes are qualified by CE (the SMP clock enable).
//   Optional feature: define SMP_TIMER_IRQ_EN to add the IRQ port with one
//   level interrupt per timer. Without it the port and logic are absent.
module smp_timer_bank #(
    parameter int                        NUM_TIMERS = 3,
    parameter int                        DIV_W      = 8,
    parameter int                        OUT_W      = 4,
    parameter int                        PRE_SLOW   = 128,
    parameter int                        PRE_FAST   = 16,
    parameter logic [NUM_TIMERS-1:0]     FAST_MASK  = 3'b100
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         CE,
    input  logic                         EN_WR,
    input  logic [NUM_TIMERS-1:0]        EN_DATA,
    input  logic [NUM_TIMERS-1:0]        DIV_WR,
    input  logic [DIV_W-1:0]             DIV_DATA,
    input  logic [NUM_TIMERS-1:0]        OUT_RD,
    output logic [NUM_TIMERS*OUT_W-1:0]  OUT,
    output logic [NUM_TIMERS*DIV_W-1:0]  DIV_Q,
    output logic [NUM_TIMERS-1:0]        TICK
`ifdef SMP_TIMER_IRQ_EN
    ,
    output logic [NUM_TIMERS-1:0]        IRQ
`endif
);

    // Prescaler width covers one slow period; the fast tick is taken from
    // its low bits, so both periods must be powers of two.
    localparam int               PRE_W         = (PRE_SLOW > 1) ? $clog2(PRE_SLOW) : 1;
    localparam logic [PRE_W-1:0] PRE_SLOW_LAST = PRE_W'(PRE_SLOW - 1);
    localparam logic [PRE_W-1:0] PRE_FAST_LOW  = PRE_W'(PRE_FAST - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_slow_tick;
    logic             w_fast_tick;

    // Shared free-running prescaler, advanced once per CE
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pre <= '0;
        end else if (CE) begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Ticks are decoded from the current prescaler value and used in the same cycle
    assign w_slow_tick = (r_pre == PRE_SLOW_LAST);
    assign w_fast_tick = ((r_pre & PRE_FAST_LOW) == PRE_FAST_LOW);

    generate
        for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_timer
            logic             r_en;
            logic [DIV_W-1:0] r_div;
            logic [DIV_W-1:0] r_cnt;
            logic [OUT_W-1:0] r_out;
            logic             r_tick;

            logic             w_tick_sel;
            logic             w_en_rise;
            logic             w_adv;
            logic [DIV_W-1:0] w_cnt_inc;
            logic             w_wrap;
            logic             w_bump;
            logic             w_rd;

            assign w_tick_sel = FAST_MASK[g] ? w_fast_tick : w_slow_tick;
            // A 0->1 enable restarts the timer and swallows any tick that cycle
            assign w_en_rise  = CE & EN_WR & EN_DATA[g] & ~r_en;
            assign w_adv      = CE & r_en & w_tick_sel & ~w_en_rise;
            // Compare against the divisor held before any same-cycle write;
            // divisor 0 matches when the counter wraps, giving 2^DIV_W ticks
            assign w_cnt_inc  = r_cnt + DIV_W'(1);
            assign w_wrap     = (w_cnt_inc == r_div);
            assign w_bump     = w_adv & w_wrap;
            assign w_rd       = CE & OUT_RD[g];

            // Enable and divisor registers, written by CE-qualified strobes
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_en  <= 1'b0;
                    r_div <= '1;
                end else if (CE) begin
                    if (EN_WR) begin
                        r_en <= EN_DATA[g];
                    end
                    if (DIV_WR[g]) begin
                        r_div <= DIV_DATA;
                    end
                end
            end

            // Stage-2 divider counter; a divisor write does not reset it
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_cnt <= '0;
                end else if (w_en_rise) begin
                    r_cnt <= '0;
                end else if (w_adv) begin
                    r_cnt <= w_wrap ? '0 : w_cnt_inc;
                end
            end

            // Output counter; an increment coinciding with a read leaves 1 so it is never lost
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_out <= '0;
                end else if (w_en_rise) begin
                    r_out <= '0;
                end else if (w_bump) begin
                    r_out <= w_rd ? OUT_W'(1) : r_out + OUT_W'(1);
                end else if (w_rd) begin
                    r_out <= '0;
                end
            end

            // One-cycle pulse following each output increment
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= w_bump;
                end
            end

            assign OUT[g*OUT_W +: OUT_W]   = r_out;
            assign DIV_Q[g*DIV_W +: DIV_W] = r_div;
            assign TICK[g]                 = r_tick;

`ifdef SMP_TIMER_IRQ_EN
            logic r_irq;

            // Level interrupt: set by an increment, cleared by read or re-enable; set wins
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_irq <= 1'b0;
                end else if (w_bump) begin
                    r_irq <= 1'b1;
                end else if (w_rd | w_en_rise) begin
                    r_irq <= 1'b0;
                end
            end

            assign IRQ[g] = r_irq;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_smp_timer_bank.sv
// tb_smp_timer_bank
//   Self-checking bench for smp_timer_bank (default parameters). A behavioural
//   model steps alongside the DUT every clock; table vectors and hand-written
//   sequences add fixed expectations for the timing corner cases.
//   Define SMP_TIMER_IRQ_EN to also exercise the IRQ port.
`timescale 1ns/1ps
module tb_smp_timer_bank;

    localparam int         NT = 3;
    localparam int         DW = 8;
    localparam int         OW = 4;
    localparam int         PS = 128;
    localparam int         PF = 16;
    localparam logic [2:0] FM = 3'b100;

    logic        CLK;
    logic        RST_N;
    logic        CE;
    logic        EN_WR;
    logic [2:0]  EN_DATA;
    logic [2:0]  DIV_WR;
    logic [7:0]  DIV_DATA;
    logic [2:0]  OUT_RD;
    logic [11:0] OUT;
    logic [23:0] DIV_Q;
    logic [2:0]  TICK;
`ifdef SMP_TIMER_IRQ_EN
    logic [2:0]  IRQ;
`endif

    smp_timer_bank #(
        .NUM_TIMERS(NT), .DIV_W(DW), .OUT_W(OW),
        .PRE_SLOW(PS), .PRE_FAST(PF), .FAST_MASK(FM)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .EN_WR(EN_WR), .EN_DATA(EN_DATA),
        .DIV_WR(DIV_WR), .DIV_DATA(DIV_DATA), .OUT_RD(OUT_RD),
        .OUT(OUT), .DIV_Q(DIV_Q), .TICK(TICK)
`ifdef SMP_TIMER_IRQ_EN
        , .IRQ(IRQ)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_ce;
    int m_cnt [NT];
    int m_out [NT];
    int m_div [NT];
    bit m_en  [NT];
    bit m_tick[NT];
    bit m_irq [NT];
    int cur_idx;

    typedef struct {
        logic        ce;
        logic        en_wr;
        logic [2:0]  en_data;
        logic [2:0]  div_wr;
        logic [7:0]  div_data;
        logic [2:0]  out_rd;
        logic [23:0] exp_divq;
        logic [11:0] exp_out;
        logic [2:0]  exp_tick;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a timer counts ticks; when count+1 reaches its period (divisor,
    // 0 meaning 256) the output goes up and the count restarts. A count past
    // the period simply runs on modulo 256.
    task automatic model_update();
        bit slow, fast, tk, rise, inc, rd;
        int period;
        if (!RST_N) begin
            m_ce = 0;
            for (int i = 0; i < NT; i++) begin
                m_en[i] = 0; m_cnt[i] = 0; m_out[i] = 0; m_div[i] = 255;
                m_tick[i] = 0; m_irq[i] = 0;
            end
            return;
        end
        for (int i = 0; i < NT; i++) m_tick[i] = 0;
        if (!CE) return;
        cur_idx = m_ce;
        slow = ((m_ce % PS) == PS - 1);
        fast = ((m_ce % PF) == PF - 1);
        for (int i = 0; i < NT; i++) begin
            tk     = FM[i] ? fast : slow;
            rise   = EN_WR && EN_DATA[i] && !m_en[i];
            rd     = OUT_RD[i];
            period = (m_div[i] == 0) ? 256 : m_div[i];
            inc    = 0;
            if (rise) begin
                m_cnt[i] = 0;
                m_out[i] = 0;
            end else if (m_en[i] && tk) begin
                if (m_cnt[i] + 1 == period) begin
                    inc = 1;
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = (m_cnt[i] + 1) % 256;
                end
            end
            if (!rise) begin
                if (inc) m_out[i] = rd ? 1 : (m_out[i] + 1) % 16;
                else if (rd) m_out[i] = 0;
            end
            if (inc) m_irq[i] = 1;
            else if (rd || rise) m_irq[i] = 0;
            m_tick[i] = inc;
        end
        for (int i = 0; i < NT; i++) begin
            if (EN_WR) m_en[i] = EN_DATA[i];
            if (DIV_WR[i]) m_div[i] = int'(DIV_DATA);
        end
        m_ce++;
    endtask

    function automatic logic [63:0] exp_out();
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < NT; i++) v[i*4 +: 4] = 4'(m_out[i]);
        return 64'(v);
    endfunction

    function automatic logic [63:0] exp_divq();
        logic [23:0] v;
        v = '0;
        for (int i = 0; i < NT; i++) v[i*8 +: 8] = 8'(m_div[i]);
        return 64'(v);
    endfunction

    function automatic logic [63:0] exp_bits(input int which);
        logic [2:0] v;
        v = '0;
        for (int i = 0; i < NT; i++) v[i] = (which == 0) ? m_tick[i] : m_irq[i];
        return 64'(v);
    endfunction

    task automatic step(input logic ce_i, input logic ew_i, input logic [2:0] ed_i,
                        input logic [2:0] dw_i, input logic [7:0] dd_i, input logic [2:0] rd_i);
        CE = ce_i; EN_WR = ew_i; EN_DATA = ed_i;
        DIV_WR = dw_i; DIV_DATA = dd_i; OUT_RD = rd_i;
        @(posedge CLK);
        model_update();
        #1;
        chk("model_out",  64'(OUT),   exp_out());
        chk("model_divq", 64'(DIV_Q), exp_divq());
        chk("model_tick", 64'(TICK),  exp_bits(0));
`ifdef SMP_TIMER_IRQ_EN
        chk("model_irq",  64'(IRQ),   exp_bits(1));
`endif
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step(1'b1, 1'b0, 3'b0, 3'b0, 8'h0, 3'b0);
        step(1'b1, 1'b0, 3'b0, 3'b0, 8'h0, 3'b0);
        RST_N = 1'b1;
    endtask

    task automatic run_ce(input int n, input int t, output int nt, output int f1, output int f2);
        nt = 0; f1 = -1; f2 = -1;
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b0, 3'b0, 3'b0, 8'h0, 3'b0);
            if (TICK[t]) begin
                nt++;
                if (f1 < 0) f1 = cur_idx;
                else if (f2 < 0) f2 = cur_idx;
            end
        end
    endtask

    initial begin
        int nt, f1, f2;
        RST_N = 1'b0; CE = 1'b0; EN_WR = 1'b0; EN_DATA = '0;
        DIV_WR = '0; DIV_DATA = '0; OUT_RD = '0;
        cur_idx = 0;

        // Reset state
        do_reset();
        chk("rst_out",  64'(OUT),   64'h0);
        chk("rst_divq", 64'(DIV_Q), 64'hFFFFFF);
        chk("rst_tick", 64'(TICK),  64'h0);
`ifdef SMP_TIMER_IRQ_EN
        chk("rst_irq",  64'(IRQ),   64'h0);
`endif

        // Register-level vectors (no prescaler tick occurs this early)
        tbl[0] = '{1'b0, 1'b0, 3'b000, 3'b111, 8'h05, 3'b000, 24'hFFFFFF, 12'h0, 3'b0};
        tbl[1] = '{1'b1, 1'b0, 3'b000, 3'b001, 8'h05, 3'b000, 24'hFFFF05, 12'h0, 3'b0};
        tbl[2] = '{1'b1, 1'b0, 3'b000, 3'b110, 8'h00, 3'b000, 24'h000005, 12'h0, 3'b0};
        tbl[3] = '{1'b0, 1'b1, 3'b111, 3'b000, 8'h00, 3'b000, 24'h000005, 12'h0, 3'b0};
        tbl[4] = '{1'b1, 1'b0, 3'b000, 3'b010, 8'h80, 3'b000, 24'h008005, 12'h0, 3'b0};
        tbl[5] = '{1'b1, 1'b0, 3'b000, 3'b000, 8'h00, 3'b111, 24'h008005, 12'h0, 3'b0};
        tbl[6] = '{1'b1, 1'b1, 3'b001, 3'b001, 8'hFE, 3'b000, 24'h0080FE, 12'h0, 3'b0};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].ce, tbl[i].en_wr, tbl[i].en_data, tbl[i].div_wr, tbl[i].div_data, tbl[i].out_rd);
            chk($sformatf("tbl%0d_divq", i), 64'(DIV_Q), 64'(tbl[i].exp_divq));
            chk($sformatf("tbl%0d_out", i),  64'(OUT),   64'(tbl[i].exp_out));
            chk($sformatf("tbl%0d_tick", i), 64'(TICK),  64'(tbl[i].exp_tick));
        end

        // Timer 0, divisor 2, slow tick: increments after CE 255 and 511
        do_reset();
        step(1'b1, 1'b1, 3'b001, 3'b001, 8'd2, 3'b000);
        run_ce(511, 0, nt, f1, f2);
        chk("a_ntick", 64'(nt), 64'd2);
        chk("a_tick1", 64'(f1), 64'd255);
        chk("a_tick2", 64'(f2), 64'd511);
        chk("a_out0",  64'(OUT[3:0]),  64'd2);
        chk("a_out12", 64'(OUT[11:4]), 64'd0);

        // Timer 2, divisor 0, fast tick: first increment after 4096 CE, then wrap
        do_reset();
        step(1'b1, 1'b1, 3'b100, 3'b100, 8'd0, 3'b000);
        run_ce(4095, 2, nt, f1, f2);
        chk("b_ntick", 64'(nt), 64'd1);
        chk("b_tick1", 64'(f1), 64'd4095);
        chk("b_out2",  64'(OUT[11:8]), 64'd1);
        step(1'b1, 1'b0, 3'b000, 3'b100, 8'd1, 3'b000);
        run_ce(240, 2, nt, f1, f2);
        chk("b_wrap_ntick", 64'(nt), 64'd15);
        chk("b_wrap_out2",  64'(OUT[11:8]), 64'd0);

        // Read coincident with increment 5->6 leaves 1; plain read clears
        do_reset();
        step(1'b1, 1'b1, 3'b001, 3'b001, 8'd1, 3'b000);
        run_ce(766, 0, nt, f1, f2);
        chk("c_out0_pre", 64'(OUT[3:0]), 64'd5);
`ifdef SMP_TIMER_IRQ_EN
        chk("c_irq_set", 64'(IRQ[0]), 64'd1);
`endif
        step(1'b1, 1'b0, 3'b000, 3'b000, 8'd0, 3'b001);
        chk("c_out0_incrd", 64'(OUT[3:0]), 64'd1);
        chk("c_tick0",      64'(TICK[0]),  64'd1);
`ifdef SMP_TIMER_IRQ_EN
        chk("c_irq_incrd", 64'(IRQ[0]), 64'd1);
`endif
        step(1'b1, 1'b0, 3'b000, 3'b000, 8'd0, 3'b001);
        chk("c_out0_rd", 64'(OUT[3:0]), 64'd0);
`ifdef SMP_TIMER_IRQ_EN
        chk("c_irq_rd", 64'(IRQ[0]), 64'd0);
`endif

        // Disable holds OUT; re-enable clears OUT and the divider count
        do_reset();
        step(1'b1, 1'b1, 3'b001, 3'b001, 8'd2, 3'b000);
        run_ce(899, 0, nt, f1, f2);
        chk("d_out0_run", 64'(OUT[3:0]), 64'd3);
        step(1'b1, 1'b1, 3'b000, 3'b000, 8'd0, 3'b000);
        run_ce(1000, 0, nt, f1, f2);
        chk("d_hold_ntick", 64'(nt), 64'd0);
        chk("d_hold_out0",  64'(OUT[3:0]), 64'd3);
        step(1'b1, 1'b1, 3'b001, 3'b000, 8'd0, 3'b000);
        chk("d_reen_out0", 64'(OUT[3:0]), 64'd0);
`ifdef SMP_TIMER_IRQ_EN
        chk("d_reen_irq", 64'(IRQ[0]), 64'd0);
`endif
        run_ce(200, 0, nt, f1, f2);
        chk("d_reen_tick1", 64'(f1), 64'd2047);

        // Divisor shrunk below the running count: count runs to wrap first
        do_reset();
        step(1'b1, 1'b1, 3'b100, 3'b000, 8'd0, 3'b000);
        run_ce(159, 2, nt, f1, f2);
        chk("e_pre_ntick", 64'(nt), 64'd0);
        step(1'b1, 1'b0, 3'b000, 3'b100, 8'd5, 3'b000);
        run_ce(4140, 2, nt, f1, f2);
        chk("e_ntick", 64'(nt), 64'd2);
        chk("e_tick1", 64'(f1), 64'd4175);
        chk("e_tick2", 64'(f2), 64'd4255);
        chk("e_out2",  64'(OUT[11:8]), 64'd2);

        // Randomized traffic against the model
        do_reset();
        step(1'b1, 1'b1, 3'b111, 3'b111, 8'd2, 3'b000);
        for (int k = 0; k < 6000; k++) begin
            logic       ce_r, ew_r;
            logic [2:0] ed_r, dw_r, rd_r;
            logic [7:0] dd_r;
            ce_r = ($urandom_range(0, 9) != 0);
            ew_r = ($urandom_range(0, 59) == 0);
            ed_r = 3'($urandom);
            dw_r = {($urandom_range(0, 99) == 0), ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) == 0)};
            dd_r = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
            rd_r = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
            step(ce_r, ew_r, ed_r, dw_r, dd_r, rd_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
